i2c_slave_responder: RTL and testbench

//  Synthesizable I2C target (slave) responding to the I2C master DUT's SCL/SDA pads.

---
 rtl/i2c_slave_responder_if.sv | 11 +
 rtl/i2c_slave_responder.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_responder_if.sv
// I2C pad bundle between a bus master (or bench) and the target responder.
// The slave samples the resolved SCL/SDA levels and returns an open-drain SDA drive.
interface i2c_slave_responder_if;
  logic scl_pad_i;
  logic sda_pad_i;
  logic sda_pad_o;
  logic sda_padoen_o;

  modport slave  (input scl_pad_i, sda_pad_i, output sda_pad_o, sda_padoen_o);
  modport master (output scl_pad_i, sda_pad_i, input sda_pad_o, sda_padoen_o);
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match and an
// auto-incrementing NUM_REGS x 8 register file (pointer write, data write, data read).
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        pclk,
  input  logic                        s_reset,
  i2c_slave_responder_if.slave        bus,
  output logic                        start_det,
  output logic                        stop_det,
  output logic                        busy,
  output logic                        reg_wr_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
  output logic [7:0]                  reg_wr_data
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, RDATA, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_q, r_sda_q;
  state_t                 r_state, w_state_nx;
  logic [3:0]             r_cnt, w_cnt_nx;
  logic [6:0]             r_shift, w_shift_nx;
  logic [7:0]             r_tx, w_tx_nx;
  logic                   r_oen, w_oen_nx;
  logic                   r_rw, w_rw_nx;
  logic [AW-1:0]          r_ptr, w_ptr_nx;
  logic                   r_busy;
  logic                   r_start_det, r_stop_det, r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic [7:0]             r_wr_data;
  logic [7:0]             r_regs [NUM_REGS];

  logic       w_scl_s, w_sda_s;
  logic       w_start, w_stop, w_rise, w_fall;
  logic [7:0] w_byte;
  logic [7:0] w_rd_byte;
  logic       w_wr_en;

  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
  assign w_start   = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
  assign w_stop    = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
  assign w_rise    = w_scl_s & ~r_scl_q;
  assign w_fall    = ~w_scl_s & r_scl_q;
  assign w_byte    = {r_shift, w_sda_s};
  assign w_rd_byte = r_regs[r_ptr];

  // r_cnt counts SCL rises in a 9-clock frame: 8 = byte done (ACK slot), 9 = ACK clock seen.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_oen_nx   = r_oen;
    w_rw_nx    = r_rw;
    w_ptr_nx   = r_ptr;
    w_wr_en    = 1'b0;
    if (w_stop) begin
      w_state_nx = IDLE;
      w_cnt_nx   = 4'd0;
      w_oen_nx   = 1'b1;
    end else if (w_start) begin
      w_state_nx = ADDR;
      w_cnt_nx   = 4'd0;
      w_oen_nx   = 1'b1;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_rise) begin
            w_shift_nx = w_byte[6:0];
            w_cnt_nx   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_state_nx = ADDR_ACK;
                w_rw_nx    = w_byte[0];
              end else begin
                w_state_nx = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, PTR, WDATA: begin
          if (r_cnt < 4'd8) begin
            if (w_rise) begin
              w_shift_nx = w_byte[6:0];
              w_cnt_nx   = r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                if (r_state == PTR) begin
                  w_ptr_nx = w_byte[AW-1:0];
                end else begin
                  w_wr_en  = 1'b1;
                  w_ptr_nx = r_ptr + 1'b1;
                end
              end
            end
          end else if (r_cnt == 4'd8) begin
            if (w_fall) w_oen_nx = 1'b0;
            if (w_rise) w_cnt_nx = 4'd9;
          end else if (w_fall) begin
            w_cnt_nx = 4'd0;
            w_oen_nx = 1'b1;
            if (r_state == ADDR_ACK) begin
              if (r_rw) begin
                w_state_nx = RDATA;
                w_tx_nx    = w_rd_byte;
                w_oen_nx   = w_rd_byte[7];
              end else begin
                w_state_nx = PTR;
              end
            end else begin
              w_state_nx = WDATA;
            end
          end
        end
        RDATA: begin
          if (r_cnt < 4'd8) begin
            if (w_rise) w_cnt_nx = r_cnt + 4'd1;
            if (w_fall && r_cnt != 4'd0) begin
              w_tx_nx  = {r_tx[6:0], 1'b0};
              w_oen_nx = r_tx[6];
            end
          end else if (r_cnt == 4'd8) begin
            if (w_fall) w_oen_nx = 1'b1;
            if (w_rise) begin
              if (w_sda_s) begin
                w_state_nx = WAIT_STOP;
                w_cnt_nx   = 4'd0;
              end else begin
                w_ptr_nx = r_ptr + 1'b1;
                w_cnt_nx = 4'd9;
              end
            end
          end else if (w_fall) begin
            w_cnt_nx = 4'd0;
            w_tx_nx  = w_rd_byte;
            w_oen_nx = w_rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (s_reset) begin
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_q     <= 1'b1;
      r_sda_q     <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_oen       <= 1'b1;
      r_rw        <= 1'b0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_pad_i};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_pad_i};
      r_scl_q     <= w_scl_s;
      r_sda_q     <= w_sda_s;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_tx        <= w_tx_nx;
      r_oen       <= w_oen_nx;
      r_rw        <= w_rw_nx;
      r_ptr       <= w_ptr_nx;
      r_start_det <= w_start & ~w_stop;
      r_stop_det  <= w_stop;
      r_wr_en     <= w_wr_en;
      if (w_stop)       r_busy <= 1'b0;
      else if (w_start) r_busy <= 1'b1;
      if (w_wr_en) begin
        r_wr_addr      <= r_ptr;
        r_wr_data      <= w_byte;
        r_regs[r_ptr]  <= w_byte;
      end
    end
  end

  assign bus.sda_pad_o    = 1'b0;
  assign bus.sda_padoen_o = r_oen;
  assign start_det        = r_start_det;
  assign stop_det         = r_stop_det;
  assign busy             = r_busy;
  assign reg_wr_en        = r_wr_en;
  assign reg_wr_addr      = r_wr_addr;
  assign reg_wr_data      = r_wr_data;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: table of directed transactions, hand-built corner
// sequences and randomized transfers scored against a byte-level register model.
module tb_i2c_slave_responder;
  localparam int NUM_REGS = 16;
  localparam int AW       = 4;
  localparam int H        = 6;

  logic          pclk;
  logic          s_reset;
  logic          r_m_scl, r_m_sda;
  logic          start_det, stop_det, busy, reg_wr_en;
  logic [AW-1:0] reg_wr_addr;
  logic [7:0]    reg_wr_data;

  int n_vec = 0, n_err = 0;
  int n_start = 0, n_stop = 0, n_oen_low = 0;
  logic [AW+7:0] wr_q[$];
  logic [7:0]    mem_m [NUM_REGS];
  int            ptr_m;

  i2c_slave_responder_if bus();
  assign bus.scl_pad_i = r_m_scl;
  assign bus.sda_pad_i = r_m_sda & (bus.sda_padoen_o | bus.sda_pad_o);

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .s_reset(s_reset), .bus(bus),
    .start_det(start_det), .stop_det(stop_det), .busy(busy),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (reg_wr_en) wr_q.push_back({reg_wr_addr, reg_wr_data});
    if (!bus.sda_padoen_o) n_oen_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic i2c_start();
    r_m_sda = 1'b1; hold(H);
    r_m_scl = 1'b1; hold(H);
    r_m_sda = 1'b0; hold(H);
    r_m_scl = 1'b0; hold(2);
  endtask

  task automatic i2c_stop();
    r_m_sda = 1'b0; hold(H);
    r_m_scl = 1'b1; hold(H);
    r_m_sda = 1'b1; hold(H);
  endtask

  // One SCL clock; the line level is sampled mid-high.
  task automatic clk_bit(input logic b, output logic smp);
    r_m_sda = b; hold(H);
    r_m_scl = 1'b1; hold(H/2);
    smp = bus.sda_pad_i; hold(H - H/2);
    r_m_scl = 1'b0; hold(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack_line);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(mack, s);
  endtask

  task automatic xfer_write(input logic [7:0] dev, input logic [7:0] p, input int n,
                            input logic [31:0] dat, output logic acked);
    logic          ack;
    logic [7:0]    d;
    logic [AW+7:0] exp_q[$];
    bit            hit;
    hit = (dev[7:1] == 7'h50) && (dev[0] == 1'b0);
    wr_q.delete();
    i2c_start();
    check("busy_in_xfer", busy, 1);
    send_byte(dev, ack);
    acked = !ack;
    check("addr_ack", !ack, hit);
    send_byte(p, ack);
    check("ptr_ack", !ack, hit);
    if (hit) ptr_m = p % NUM_REGS;
    for (int i = 0; i < n; i++) begin
      d = dat[8*i +: 8];
      send_byte(d, ack);
      check("data_ack", !ack, hit);
      if (hit) begin
        exp_q.push_back({ptr_m[AW-1:0], d});
        mem_m[ptr_m] = d;
        ptr_m = (ptr_m + 1) % NUM_REGS;
      end
    end
    i2c_stop();
    hold(4);
    check("busy_after_stop", busy, 0);
    check("wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check("wr_event", wr_q[i], exp_q[i]);
  endtask

  task automatic xfer_read(input bit set_ptr, input logic [7:0] p, input int n,
                           output logic [15:0] got);
    logic       ack;
    logic [7:0] d;
    got = '0;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hA0, ack);
      check("rd_wr_addr_ack", ack, 0);
      send_byte(p, ack);
      check("rd_ptr_ack", ack, 0);
      ptr_m = p % NUM_REGS;
      i2c_start();
    end
    send_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check("rd_data", d, mem_m[ptr_m]);
      got = {got[7:0], d};
      if (i < n - 1) ptr_m = (ptr_m + 1) % NUM_REGS;
    end
    i2c_stop();
    hold(4);
    check("rd_busy_after_stop", busy, 0);
  endtask

  typedef struct {
    bit          is_read;
    logic [7:0]  dev;
    logic [7:0]  ptr;
    int          n;
    logic [31:0] dat;
    bit          exp_ack;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        tbl [5];
  logic        ack, s, ack_seen;
  logic [15:0] got;
  int          s0, p0, o0, op, n, pick;
  logic [7:0]  p, dev;
  logic [31:0] dat;

  initial begin
    tbl[0] = '{0, 8'hA0, 8'h03, 2, 32'h0000_C35A, 1, 16'h0000};
    tbl[1] = '{1, 8'hA1, 8'h03, 2, 32'h0,         1, 16'h5AC3};
    tbl[2] = '{0, 8'hA2, 8'h00, 0, 32'h0,         0, 16'h0000};
    tbl[3] = '{0, 8'hA0, 8'h0F, 2, 32'h0000_2211, 1, 16'h0000};
    tbl[4] = '{1, 8'hA1, 8'h0F, 2, 32'h0,         1, 16'h1122};
    for (int i = 0; i < NUM_REGS; i++) mem_m[i] = 8'h00;
    ptr_m = 0;

    r_m_scl = 1'b1;
    r_m_sda = 1'b1;
    s_reset = 1'b1;
    hold(3);
    check("rst_oen", bus.sda_padoen_o, 1);
    check("rst_sda_o", bus.sda_pad_o, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start_det, 0);
    check("rst_stop", stop_det, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_wr_addr", reg_wr_addr, 0);
    check("rst_wr_data", reg_wr_data, 0);
    s_reset = 1'b0;
    hold(4);

    // START/STOP pulse latency: pad edge shows up three pclk later.
    r_m_sda = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      hold(1);
      check("start_latency", start_det, (k == 3));
    end
    check("busy_after_start", busy, 1);
    hold(H); r_m_scl = 1'b0; hold(H); r_m_scl = 1'b1; hold(H);
    r_m_sda = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      hold(1);
      check("stop_latency", stop_det, (k == 3));
    end
    check("busy_after_stop_lat", busy, 0);
    hold(4);

    for (int i = 0; i < 5; i++) begin
      if (!tbl[i].is_read) begin
        s0 = n_start; p0 = n_stop; o0 = n_oen_low;
        xfer_write(tbl[i].dev, tbl[i].ptr, tbl[i].n, tbl[i].dat, ack_seen);
        check("tbl_addr_ack", ack_seen, tbl[i].exp_ack);
        check("tbl_start_pulses", n_start - s0, 1);
        check("tbl_stop_pulses", n_stop - p0, 1);
        if (!tbl[i].exp_ack) check("tbl_miss_oen_low", n_oen_low - o0, 0);
      end else begin
        xfer_read(1'b1, tbl[i].ptr, tbl[i].n, got);
        check("tbl_rd", got, tbl[i].exp_rd);
      end
    end

    // Abort after four data bits: nothing is written and the bus is free again.
    wr_q.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    check("abort_addr_ack", ack, 0);
    send_byte(8'h05, ack);
    check("abort_ptr_ack", ack, 0);
    ptr_m = 5;
    for (int i = 0; i < 4; i++) clk_bit(i[0], s);
    i2c_stop();
    hold(4);
    check("abort_no_write", wr_q.size(), 0);
    check("abort_busy", busy, 0);
    xfer_write(8'hA0, 8'h06, 1, 32'h77, ack_seen);
    check("abort_reack", ack_seen, 1);
    xfer_read(1'b1, 8'h05, 2, got);
    check("abort_rd", got, 16'h0077);

    // Reset while the slave drives a 0 read bit (MSB of 0x5A in reg 3).
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    check("rst_mid_addr_ack", ack, 0);
    hold(H);
    check("rst_mid_driving", bus.sda_padoen_o, 0);
    s_reset = 1'b1;
    @(posedge pclk);
    #1;
    check("rst_mid_release", bus.sda_padoen_o, 1);
    hold(2);
    s_reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    for (int i = 0; i < NUM_REGS; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    i2c_stop();
    hold(4);
    xfer_read(1'b1, 8'h03, 1, got);
    check("rst_mid_rd", got, 16'h0000);

    for (int it = 0; it < 24; it++) begin
      op   = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      p    = 8'($urandom_range(0, 255));
      dat  = $urandom;
      pick = $urandom_range(0, 1);
      if (op <= 1) begin
        xfer_write(8'hA0, p, n, dat, ack_seen);
      end else if (op == 2) begin
        xfer_read(1'b1, p, n, got);
      end else if (pick == 1) begin
        dev = {7'($urandom_range(0, 127)), 1'b0};
        if (dev[7:1] == 7'h50) dev = 8'hA2;
        o0 = n_oen_low;
        xfer_write(dev, p, n, dat, ack_seen);
        check("rnd_miss_oen_low", n_oen_low - o0, 0);
      end else begin
        xfer_read(1'b0, 8'h00, n, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
